mbus_mem_responder: RTL and testbench
=====================================

# mbus_mem_responder

Word-addressed, SRAM-backed responder for the split read/write memory bus that the vector unit's memory queue drives. It accepts read addresses on AR and returns data on R. It accepts writes as a combined AW+W beat and acknowledges each one on B. Reads pass through a fixed-latency pipeline into a response FIFO, so the initiator sees in-order data with backpressure. It sits on the memory side of the bus and serves as both the simulation memory model and a synthesizable scratchpad.

## Interface
Parameters:
- MBUS_ADDR_WIDTH, 32, byte address width
- MBUS_DATA_WIDTH, 32, data width; fixed at 32 (4 strobe bits)
- MBUS_DW_B, MBUS_DATA_WIDTH>>3, bytes per word
- MEM_DEPTH_BITS, 10, log2 of memory words
- RD_LATENCY, 2, cycles from AR acceptance to R data available; must be ≥1
- RESP_DEPTH_BITS, 3, log2 of read-response FIFO depth and of the write-ack limit

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mbus_ar_addr  in  MBUS_ADDR_WIDTH  read byte address
- mbus_ar_valid  in  1  read request valid
- mbus_ar_ready  out  1  read request accepted
- mbus_r_data  out  MBUS_DATA_WIDTH  read data
- mbus_r_valid  out  1  read data valid
- mbus_r_ready  in  1  initiator takes read data
- mbus_aw_addr  in  MBUS_ADDR_WIDTH  write byte address
- mbus_aw_valid  in  1  write address valid
- mbus_aw_ready  out  1  write accepted; also consumes W, since there is no separate w_ready
- mbus_w_data  in  MBUS_DATA_WIDTH  write data
- mbus_w_valid  in  1  write data valid
- mbus_w_strb  in  MBUS_DW_B  byte enables
- mbus_b_resp  out  1  0 = OK, 1 = address out of range
- mbus_b_valid  out  1  write ack valid
- mbus_b_ready  in  1  initiator takes ack

## Operation
- **Address decode:**
  - Word index = addr[MEM_DEPTH_BITS+1:2]; addr[1:0] is ignored.
  - Out of range: any addr bit above MEM_DEPTH_BITS+1 is set.
- **Read acceptance:** a read is accepted when ar_valid & ar_ready.
- **Read pipeline:**
  - The word is sampled at acceptance and travels through RD_LATENCY pipeline stages into the response FIFO (depth 2^RESP_DEPTH_BITS).
  - An out-of-range read returns 0.
- **Read backpressure:** ar_ready = (in-flight pipeline entries + FIFO count) < 2^RESP_DEPTH_BITS. No response is ever dropped.
- **Read response:**
  - r_valid = FIFO non-empty; the FIFO pops on r_valid & r_ready.
  - R data is returned in acceptance order.
- **Write acceptance:** a write is accepted when aw_valid & w_valid & aw_ready.
  - aw_valid without w_valid is not accepted.
  - W is never consumed without AW.
- **Write effect:**
  - Each byte i with strb[i]=1 is written at the end of the acceptance cycle.
  - An out-of-range write is discarded with no memory change, and its ack carries resp=1.
- **Write acks:**
  - An ack queue (depth 2^RESP_DEPTH_BITS) holds one resp bit per accepted write.
  - b_valid = queue non-empty; pop on b_valid & b_ready.
  - aw_ready = queue not full.
  - Accept and pop in the same cycle leaves the count unchanged, and a write is still accepted while the queue is full if a pop occurs in that cycle.
- **Same-cycle read and write to one word:** the read returns pre-write data.
- **Ordering:** reads and writes are otherwise independent; there is no ordering between the R and B channels.

## Timing
- **Reset (rst_n=0 at an edge):**
  - Pipeline, FIFO and ack queue are flushed; outstanding responses are lost.
  - Memory contents are not reset.
  - During reset all outputs are 0: ar_ready, aw_ready, r_valid, b_valid, r_data, b_resp.
- **After reset:** ar_ready=1 and aw_ready=1 in the first cycle with rst_n=1.
- **Read latency:** AR accepted in cycle T gives r_valid=1 in cycle T+RD_LATENCY with r_ready held high. There is one beat per cycle of sustained throughput.
- **Write ack latency:** a write accepted in cycle T gives b_valid=1 in cycle T+1.
- **Stable outputs:** r_data and b_resp hold stable while valid=1 and ready=0.
- **Pointer arithmetic:** FIFO and queue pointers are RESP_DEPTH_BITS wide and wrap modulo depth. Counts are RESP_DEPTH_BITS+1 wide so full and empty are distinguishable.

## Configuration
- **MBUS_MEM_RESP_STALL_EN defined:**
  - A 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle after reset.
  - ar_ready is additionally ANDed with LFSR bit 0, and aw_ready with LFSR bit 1.
  - This exercises initiator backpressure.
- **Undefined:** ready depends only on capacity, exactly as in Operation.

## Test plan
- **Write then read:** write 0xDEADBEEF to 0x10 with strb 4'hF, then read 0x10. Required: b_valid at T+1 with resp=0; r_data=0xDEADBEEF at T'+2.
- **Partial strobe:** pre-load 0x11223344 at 0x20, write 0xAABBCCDD with strb 4'b0101, then read. Required: 0x11BB33DD.
- **Read backpressure:** hold r_ready=0 and issue 10 reads with depth 8. Required: ar_ready drops after the 8th accept; raising r_ready drains the data in order, then ar_ready returns.
- **Out of range:** write and then read address 1<<(MEM_DEPTH_BITS+2). Required: b_resp=1, r_data=0, no memory change at word 0.
- **Ack queue full:** hold b_ready=0 and issue 8 writes. Required: aw_ready=0. Then one pop with a simultaneous 9th write is accepted and b_valid stays 1.
- **Reset mid-operation:** assert rst_n=0 with 3 reads in flight. Required: all outputs 0 during reset, no stale r_valid afterwards, and data written before reset still reads back.

Source files
------------

// File: rtl/mbus_mem_if.sv
// mbus_mem_if: split read/write memory bus between an initiator
// (master) and a memory-side responder (slave).
interface mbus_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW >> 3
);
  logic [AW-1:0] mbus_ar_addr;
  logic          mbus_ar_valid;
  logic          mbus_ar_ready;
  logic [DW-1:0] mbus_r_data;
  logic          mbus_r_valid;
  logic          mbus_r_ready;
  logic [AW-1:0] mbus_aw_addr;
  logic          mbus_aw_valid;
  logic          mbus_aw_ready;
  logic [DW-1:0] mbus_w_data;
  logic          mbus_w_valid;
  logic [SW-1:0] mbus_w_strb;
  logic          mbus_b_resp;
  logic          mbus_b_valid;
  logic          mbus_b_ready;

  modport master (
    output mbus_ar_addr, mbus_ar_valid,
    input  mbus_ar_ready,
    input  mbus_r_data, mbus_r_valid,
    output mbus_r_ready,
    output mbus_aw_addr, mbus_aw_valid,
    input  mbus_aw_ready,
    output mbus_w_data, mbus_w_valid,
    output mbus_w_strb,
    input  mbus_b_resp, mbus_b_valid,
    output mbus_b_ready
  );

  modport slave (
    input  mbus_ar_addr, mbus_ar_valid,
    output mbus_ar_ready,
    output mbus_r_data, mbus_r_valid,
    input  mbus_r_ready,
    input  mbus_aw_addr, mbus_aw_valid,
    output mbus_aw_ready,
    input  mbus_w_data, mbus_w_valid,
    input  mbus_w_strb,
    output mbus_b_resp, mbus_b_valid,
    input  mbus_b_ready
  );
endinterface

// File: rtl/mbus_mem_responder.sv
// mbus_mem_responder: SRAM-backed word responder for the split R/W bus.
// Define MBUS_MEM_RESP_STALL_EN to add LFSR-driven ready stalls.
module mbus_mem_responder #(
  parameter int MBUS_ADDR_WIDTH = 32,
  parameter int MBUS_DATA_WIDTH = 32,
  parameter int MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
  parameter int MEM_DEPTH_BITS  = 10,
  parameter int RD_LATENCY      = 2,
  parameter int RESP_DEPTH_BITS = 3
) (
  input logic       clk,
  input logic       rst_n,
  mbus_mem_if.slave mbus
);

  localparam int MEM_WORDS = 1 << MEM_DEPTH_BITS;
  localparam int DEPTH     = 1 << RESP_DEPTH_BITS;
  localparam int CW        = RESP_DEPTH_BITS + 1;
  localparam int HI        = MEM_DEPTH_BITS + 2;

  typedef logic [MBUS_DATA_WIDTH-1:0] word_t;
  typedef logic [RESP_DEPTH_BITS-1:0] ptr_t;
  typedef logic [CW-1:0]              cnt_t;
  typedef logic [MEM_DEPTH_BITS-1:0]  idx_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  // address decode
  idx_t ar_idx;
  idx_t aw_idx;
  logic ar_oor;
  logic aw_oor;
  logic [3:0] unused_addr_lsb;

  assign ar_idx = mbus.mbus_ar_addr[HI-1:2];
  assign aw_idx = mbus.mbus_aw_addr[HI-1:2];
  assign ar_oor = |mbus.mbus_ar_addr[MBUS_ADDR_WIDTH-1:HI];
  assign aw_oor = |mbus.mbus_aw_addr[MBUS_ADDR_WIDTH-1:HI];
  assign unused_addr_lsb = {mbus.mbus_ar_addr[1:0],
                            mbus.mbus_aw_addr[1:0]};

  // ready gating
  logic ar_gate;
  logic aw_gate;

`ifdef MBUS_MEM_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state, reseeded on reset
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign ar_gate = lfsr_q[0];
  assign aw_gate = lfsr_q[1];
`else
  assign ar_gate = 1'b1;
  assign aw_gate = 1'b1;
`endif

  // storage and queue state
  word_t mem_q [MEM_WORDS];

  cnt_t  occ_q, occ_d;
  word_t rf_mem_q [DEPTH];
  ptr_t  rf_wp_q, rf_wp_d;
  ptr_t  rf_rp_q, rf_rp_d;
  cnt_t  rf_cnt_q, rf_cnt_d;

  logic [DEPTH-1:0] bq_mem_q;
  ptr_t  bq_wp_q, bq_wp_d;
  ptr_t  bq_rp_q, bq_rp_d;
  cnt_t  bq_cnt_q, bq_cnt_d;

  // handshakes
  logic  ar_ready;
  logic  aw_ready;
  logic  r_valid;
  logic  b_valid;
  logic  rd_acc;
  logic  wr_acc;
  logic  r_pop;
  logic  b_pop;
  word_t rd_word;
  logic  push_v;
  word_t push_d;

  assign r_valid  = rst_n & (rf_cnt_q != '0);
  assign b_valid  = rst_n & (bq_cnt_q != '0);
  assign r_pop    = r_valid & mbus.mbus_r_ready;
  assign b_pop    = b_valid & mbus.mbus_b_ready;
  assign ar_ready = rst_n & ar_gate & (occ_q < FULL);
  assign aw_ready = rst_n & aw_gate
                  & ((bq_cnt_q < FULL) | b_pop);
  assign rd_acc   = mbus.mbus_ar_valid & ar_ready;
  assign wr_acc   = mbus.mbus_aw_valid & mbus.mbus_w_valid
                  & aw_ready;

  // pre-write word seen by a read accepted this cycle
  assign rd_word = ar_oor ? '0 : mem_q[ar_idx];

  assign mbus.mbus_ar_ready = ar_ready;
  assign mbus.mbus_aw_ready = aw_ready;
  assign mbus.mbus_r_valid  = r_valid;
  assign mbus.mbus_b_valid  = b_valid;
  assign mbus.mbus_r_data   = r_valid ? rf_mem_q[rf_rp_q] : '0;
  assign mbus.mbus_b_resp   = b_valid & bq_mem_q[bq_rp_q];

  // byte-strobed write; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (wr_acc && !aw_oor) begin
      for (int b = 0; b < MBUS_DW_B; b++) begin
        if (mbus.mbus_w_strb[b]) begin
          mem_q[aw_idx][8*b +: 8] <= mbus.mbus_w_data[8*b +: 8];
        end
      end
    end
  end

  // read pipeline: last hop lands in the FIFO
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign push_v = rd_acc;
      assign push_d = rd_word;
    end else begin : g_pipe
      localparam int NS = RD_LATENCY - 1;
      logic [NS-1:0] v_q;
      logic [NS-1:0] v_d;
      word_t         d_q [NS];

      // shift valid bits toward the FIFO
      always_comb begin
        v_d = (v_q << 1) | NS'(rd_acc);
      end

      // valid flags are flushed by reset
      always_ff @(posedge clk) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= v_d;
      end

      // data rides alongside the valid bits
      always_ff @(posedge clk) begin
        d_q[0] <= rd_word;
        for (int i = 1; i < NS; i++) begin
          d_q[i] <= d_q[i-1];
        end
      end

      assign push_v = v_q[NS-1];
      assign push_d = d_q[NS-1];
    end
  endgenerate

  // next-state for counters and pointers
  always_comb begin
    occ_d    = occ_q + cnt_t'(rd_acc) - cnt_t'(r_pop);
    rf_wp_d  = rf_wp_q + ptr_t'(push_v);
    rf_rp_d  = rf_rp_q + ptr_t'(r_pop);
    rf_cnt_d = rf_cnt_q + cnt_t'(push_v) - cnt_t'(r_pop);
    bq_wp_d  = bq_wp_q + ptr_t'(wr_acc);
    bq_rp_d  = bq_rp_q + ptr_t'(b_pop);
    bq_cnt_d = bq_cnt_q + cnt_t'(wr_acc) - cnt_t'(b_pop);
  end

  // control state, flushed on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= '0;
      rf_wp_q  <= '0;
      rf_rp_q  <= '0;
      rf_cnt_q <= '0;
      bq_wp_q  <= '0;
      bq_rp_q  <= '0;
      bq_cnt_q <= '0;
    end else begin
      occ_q    <= occ_d;
      rf_wp_q  <= rf_wp_d;
      rf_rp_q  <= rf_rp_d;
      rf_cnt_q <= rf_cnt_d;
      bq_wp_q  <= bq_wp_d;
      bq_rp_q  <= bq_rp_d;
      bq_cnt_q <= bq_cnt_d;
    end
  end

  // response FIFO payload
  always_ff @(posedge clk) begin
    if (push_v) rf_mem_q[rf_wp_q] <= push_d;
  end

  // write-ack payload
  always_ff @(posedge clk) begin
    if (wr_acc) bq_mem_q[bq_wp_q] <= aw_oor;
  end

endmodule

// File: tb/tb_mbus_mem_responder.sv
// tb_mbus_mem_responder: directed and random checks of the
// memory responder against a word-array / queue reference model.
module tb_mbus_mem_responder;

  localparam int MDB = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  mbus_mem_if #(.AW(32), .DW(32)) bus ();

  mbus_mem_responder #(
    .MBUS_ADDR_WIDTH (32),
    .MBUS_DATA_WIDTH (32),
    .MEM_DEPTH_BITS  (MDB),
    .RD_LATENCY      (2),
    .RESP_DEPTH_BITS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mbus  (bus)
  );

  always #5 clk = ~clk;

  // reference model: word array plus expected R/B queues
  logic [31:0] mm [1024];
  logic [31:0] rq [$];
  logic        bq [$];

  function automatic logic is_oor(input logic [31:0] a);
    return (a >> (MDB + 2)) != 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int k;
    k = $urandom_range(0, 15);
    if (k == 0)     a = 32'h1 << $urandom_range(12, 31);
    else if (k < 8) a = 32'($urandom_range(0, 7)) << 2;
    else            a = 32'($urandom_range(0, 1023)) << 2;
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // scoreboard: in-order R data and B resp against the model
  always @(negedge clk) begin
    logic [31:0] e;
    logic        eb;
    logic [31:0] a;
    if (!rst_n) begin
      rq.delete();
      bq.delete();
    end else begin
      if (bus.mbus_r_valid && bus.mbus_r_ready) begin
        n_cmp++;
        if (rq.size() == 0) begin
          n_bad++;
          $display("FAIL r_extra got=%h want=none",
                   bus.mbus_r_data);
        end else begin
          e = rq.pop_front();
          if (bus.mbus_r_data !== e) begin
            n_bad++;
            $display("FAIL r_data got=%h want=%h",
                     bus.mbus_r_data, e);
          end
        end
      end
      if (bus.mbus_b_valid && bus.mbus_b_ready) begin
        n_cmp++;
        if (bq.size() == 0) begin
          n_bad++;
          $display("FAIL b_extra got=%b want=none",
                   bus.mbus_b_resp);
        end else begin
          eb = bq.pop_front();
          if (bus.mbus_b_resp !== eb) begin
            n_bad++;
            $display("FAIL b_resp got=%b want=%b",
                     bus.mbus_b_resp, eb);
          end
        end
      end
      if (bus.mbus_ar_valid && bus.mbus_ar_ready) begin
        a = bus.mbus_ar_addr;
        rq.push_back(is_oor(a) ? 32'h0 : mm[widx(a)]);
      end
      if (bus.mbus_aw_valid && bus.mbus_w_valid &&
          bus.mbus_aw_ready) begin
        a = bus.mbus_aw_addr;
        bq.push_back(is_oor(a));
        if (!is_oor(a)) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.mbus_w_strb[b])
              mm[widx(a)][8*b +: 8] = bus.mbus_w_data[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic idle();
    bus.mbus_ar_valid = 1'b0;
    bus.mbus_aw_valid = 1'b0;
    bus.mbus_w_valid  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0]  s);
    bit acc = 1'b0;
    bus.mbus_aw_addr  = a;
    bus.mbus_w_data   = d;
    bus.mbus_w_strb   = s;
    bus.mbus_aw_valid = 1'b1;
    bus.mbus_w_valid  = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      #3;
      acc = bus.mbus_aw_ready;
      step();
    end
    bus.mbus_aw_valid = 1'b0;
    bus.mbus_w_valid  = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_timeout addr=%h got=no_accept want=accept", a);
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    bit acc = 1'b0;
    bus.mbus_ar_addr  = a;
    bus.mbus_ar_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      #3;
      acc = bus.mbus_ar_ready;
      step();
    end
    bus.mbus_ar_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_timeout addr=%h got=no_accept want=accept", a);
    end
  endtask

  task automatic test_reset();
    logic [37:0] o;
    rst_n = 1'b0;
    idle();
    bus.mbus_r_ready = 1'b0;
    bus.mbus_b_ready = 1'b0;
    bus.mbus_ar_addr = '0;
    bus.mbus_aw_addr = '0;
    bus.mbus_w_data  = '0;
    bus.mbus_w_strb  = '0;
    repeat (3) step();
    #3;
    o = {bus.mbus_ar_ready, bus.mbus_aw_ready, bus.mbus_r_valid,
         bus.mbus_b_valid, bus.mbus_b_resp, bus.mbus_r_data, 1'b0};
    n_cmp++;
    if (o !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_outs got=%h want=0", o);
    end
    step();
    rst_n = 1'b1;
    #3;
    n_cmp++;
    if (bus.mbus_ar_ready !== 1'b1 || bus.mbus_aw_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_ready got=%b%b want=11",
               bus.mbus_ar_ready, bus.mbus_aw_ready);
    end
    step();
  endtask

  task automatic test_preload();
    bus.mbus_r_ready = 1'b1;
    bus.mbus_b_ready = 1'b1;
    for (int w = 0; w < 1024; w++)
      do_write(32'(w) << 2, $urandom, 4'hF);
    repeat (3) step();
  endtask

  task automatic test_write_read();
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    #3;
    n_cmp++;
    if (bus.mbus_b_valid !== 1'b1 || bus.mbus_b_resp !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_ack_t1 got=%b/%b want=1/0",
               bus.mbus_b_valid, bus.mbus_b_resp);
    end
    step();
    do_read(32'h10);
    #3;
    n_cmp++;
    if (bus.mbus_r_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_early got=%b want=0", bus.mbus_r_valid);
    end
    step();
    #3;
    n_cmp++;
    if (bus.mbus_r_valid !== 1'b1 ||
        bus.mbus_r_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_t2 got=%b/%h want=1/deadbeef",
               bus.mbus_r_valid, bus.mbus_r_data);
    end
    step();
  endtask

  task automatic test_partial_strobe();
    do_write(32'h20, 32'h11223344, 4'hF);
    do_write(32'h20, 32'hAABBCCDD, 4'b0101);
    do_read(32'h20);
    step();
    #3;
    n_cmp++;
    if (bus.mbus_r_valid !== 1'b1 ||
        bus.mbus_r_data !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL strobe got=%b/%h want=1/11bb33dd",
               bus.mbus_r_valid, bus.mbus_r_data);
    end
    step();
  endtask

  task automatic test_read_backpressure();
    int acc = 0;
    bit rd;
    bus.mbus_r_ready  = 1'b0;
    bus.mbus_ar_addr  = rand_addr() & 32'hFFF;
    bus.mbus_ar_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      #3;
      rd = bus.mbus_ar_ready;
      step();
      if (rd) begin
        acc++;
        bus.mbus_ar_addr = rand_addr() & 32'hFFF;
      end
    end
    #3;
    n_cmp++;
    if (acc != 8 || bus.mbus_ar_ready !== 1'b0 ||
        bus.mbus_r_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_full got=%0d/%b/%b want=8/0/1",
               acc, bus.mbus_ar_ready, bus.mbus_r_valid);
    end
    step();
    bus.mbus_r_ready = 1'b1;
    for (int i = 0; i < 40 && acc < 10; i++) begin
      #3;
      rd = bus.mbus_ar_ready;
      step();
      if (rd) begin
        acc++;
        bus.mbus_ar_addr = rand_addr() & 32'hFFF;
      end
    end
    bus.mbus_ar_valid = 1'b0;
    for (int i = 0; i < 20 && bus.mbus_r_valid; i++) step();
    #3;
    n_cmp++;
    if (acc != 10 || bus.mbus_ar_ready !== 1'b1 ||
        bus.mbus_r_valid !== 1'b0 || rq.size() != 0) begin
      n_bad++;
      $display("FAIL bp_drain got=%0d/%b/%b/%0d want=10/1/0/0",
               acc, bus.mbus_ar_ready, bus.mbus_r_valid, rq.size());
    end
    step();
  endtask

  task automatic test_out_of_range();
    logic [31:0] w0;
    w0 = mm[0];
    do_write(32'h1 << (MDB + 2), $urandom, 4'hF);
    #3;
    n_cmp++;
    if (bus.mbus_b_valid !== 1'b1 || bus.mbus_b_resp !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_bresp got=%b/%b want=1/1",
               bus.mbus_b_valid, bus.mbus_b_resp);
    end
    step();
    do_read(32'h1 << (MDB + 2));
    step();
    #3;
    n_cmp++;
    if (bus.mbus_r_valid !== 1'b1 || bus.mbus_r_data !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_rdata got=%b/%h want=1/0",
               bus.mbus_r_valid, bus.mbus_r_data);
    end
    step();
    do_read(32'h0);
    step();
    #3;
    n_cmp++;
    if (bus.mbus_r_data !== w0) begin
      n_bad++;
      $display("FAIL oor_word0 got=%h want=%h", bus.mbus_r_data, w0);
    end
    step();
  endtask

  task automatic test_ack_full();
    bus.mbus_b_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      do_write(rand_addr() & 32'hFFF, $urandom, 4'($urandom));
    bus.mbus_aw_addr  = 32'h40;
    bus.mbus_w_data   = $urandom;
    bus.mbus_w_strb   = 4'hF;
    bus.mbus_aw_valid = 1'b1;
    bus.mbus_w_valid  = 1'b1;
    #3;
    n_cmp++;
    if (bus.mbus_aw_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_full_ready got=%b want=0",
               bus.mbus_aw_ready);
    end
    step();
    bus.mbus_b_ready = 1'b1;
    #3;
    n_cmp++;
    if (bus.mbus_aw_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_pop_accept got=%b want=1",
               bus.mbus_aw_ready);
    end
    step();
    idle();
    bus.mbus_b_ready = 1'b0;
    #3;
    n_cmp++;
    if (bus.mbus_b_valid !== 1'b1 || bus.mbus_aw_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_still_full got=%b/%b want=1/0",
               bus.mbus_b_valid, bus.mbus_aw_ready);
    end
    step();
    bus.mbus_b_ready = 1'b1;
    repeat (12) step();
    #3;
    n_cmp++;
    if (bus.mbus_b_valid !== 1'b0 || bq.size() != 0) begin
      n_bad++;
      $display("FAIL ack_drain got=%b/%0d want=0/0",
               bus.mbus_b_valid, bq.size());
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.mbus_ar_valid = 1'($urandom_range(0, 1));
      bus.mbus_ar_addr  = rand_addr();
      bus.mbus_aw_valid = ($urandom_range(0, 3) != 0);
      bus.mbus_w_valid  = ($urandom_range(0, 3) != 0);
      bus.mbus_aw_addr  = rand_addr();
      bus.mbus_w_data   = $urandom;
      bus.mbus_w_strb   = 4'($urandom);
      bus.mbus_r_ready  = ($urandom_range(0, 3) != 0);
      bus.mbus_b_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    bus.mbus_r_ready = 1'b1;
    bus.mbus_b_ready = 1'b1;
    repeat (20) step();
    #3;
    n_cmp++;
    if (rq.size() != 0 || bq.size() != 0 ||
        bus.mbus_r_valid !== 1'b0 || bus.mbus_b_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rand_drain got=%0d/%0d/%b/%b want=0/0/0/0",
               rq.size(), bq.size(),
               bus.mbus_r_valid, bus.mbus_b_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [37:0] o;
    logic [31:0] keep;
    bit stale = 1'b0;
    keep = mm[4];
    bus.mbus_r_ready  = 1'b0;
    bus.mbus_ar_addr  = 32'h10;
    bus.mbus_ar_valid = 1'b1;
    repeat (3) step();
    bus.mbus_ar_valid = 1'b0;
    rst_n = 1'b0;
    bus.mbus_aw_valid = 1'b1;
    bus.mbus_w_valid  = 1'b1;
    bus.mbus_w_strb   = 4'hF;
    bus.mbus_aw_addr  = 32'h10;
    bus.mbus_r_ready  = 1'b1;
    bus.mbus_b_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      o = {bus.mbus_ar_ready, bus.mbus_aw_ready, bus.mbus_r_valid,
           bus.mbus_b_valid, bus.mbus_b_resp, bus.mbus_r_data, 1'b0};
      n_cmp++;
      if (o !== 38'h0) begin
        n_bad++;
        $display("FAIL mid_reset_outs cyc=%0d got=%h want=0", i, o);
      end
      step();
    end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      if (bus.mbus_r_valid !== 1'b0) stale = 1'b1;
      step();
    end
    n_cmp++;
    if (stale) begin
      n_bad++;
      $display("FAIL stale_rvalid got=1 want=0");
    end
    do_read(32'h10);
    step();
    #3;
    n_cmp++;
    if (bus.mbus_r_valid !== 1'b1 || bus.mbus_r_data !== keep) begin
      n_bad++;
      $display("FAIL mem_kept got=%b/%h want=1/%h",
               bus.mbus_r_valid, bus.mbus_r_data, keep);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_partial_strobe();
    test_read_backpressure();
    test_out_of_range();
    test_ack_full();
    test_random();
    test_reset_mid();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
